// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives pc_rom and registers each word into a valid/ready stage.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HALTED = 2'd1
`ifdef FETCH_ALIGN_CHECK_EN
    , ST_ERROR = 2'd2
`endif
  } state_t;

  localparam logic [31:0] LAST_PC = RESET_PC + 32'((ROM_WORDS - 1) * 4);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;
  logic        cap;

  assign next_pc = (pc_q == LAST_PC) ? RESET_PC : pc_q + 32'd4;
  assign cap     = (state_q == ST_FETCH) && !halt && (!valid_q || inst_ready);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic redir_take;
  // Redirects are ignored once trapped; only reset leaves ERROR.
  assign redir_take = redirect_valid && (state_q != ST_ERROR);
`else
  logic redir_take;
  assign redir_take = redirect_valid;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d     = err_q;
`endif

    if (state_q == ST_FETCH && halt) begin
      state_d = ST_HALTED;
    end else if (state_q == ST_HALTED && !halt) begin
      state_d = ST_FETCH;
    end

    if (redir_take) begin
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        pc_d    = redirect_pc;
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
`else
      pc_d    = redirect_pc & ~32'h3;
      state_d = halt ? ST_HALTED : ST_FETCH;
`endif
    end else if (cap) begin
      inst_d    = rom_rd;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = next_pc;
    end else if (valid_q && inst_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign rom_addr   = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
